// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of NUM_SRC write-back sources onto
// the single register-file write port, plus the per-register busy scoreboard.
module regfile_wb_sched #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [5*NUM_SRC-1:0]    src_rd,
  input  logic [XLEN*NUM_SRC-1:0] src_data,
  output logic                    rf_w_en,
  output logic [4:0]              rf_rd,
  output logic [XLEN-1:0]         rf_w_data,
  input  logic                    rsv_en,
  input  logic [4:0]              rsv_rd,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [31:0]             busy_vec
);

  localparam int          PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned N  = NUM_SRC;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  int unsigned     cand;

  logic [4:0]      rd_a   [NUM_SRC];
  logic [XLEN-1:0] data_a [NUM_SRC];

  logic            rf_w_en_q, rf_w_en_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_w_data_q, rf_w_data_d;
  logic [31:0]     busy_q, busy_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign rd_a[g]   = src_rd[5*g +: 5];
    assign data_a[g] = src_data[XLEN*g +: XLEN];
  end

  // Search starts at ptr and wraps; the first valid source found wins.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    src_ready = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
        if (!gnt_any && src_valid[PW'(cand)]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(cand);
        end
      end
      if (gnt_any) src_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rf_w_en_d   = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_w_data_d = rf_w_data_q;
    if (gnt_any) begin
      ptr_d       = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      rf_w_en_d   = (rd_a[gnt_idx] != 5'd0);
      rf_rd_d     = rd_a[gnt_idx];
      rf_w_data_d = data_a[gnt_idx];
    end
  end

  // Clear applied before set so a same-cycle reservation of the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_w_en_q) busy_d[rf_rd_q] = 1'b0;
    if (rsv_en && (rsv_rd != 5'd0)) busy_d[rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rf_w_en_q   <= 1'b0;
      rf_rd_q     <= '0;
      rf_w_data_q <= '0;
      busy_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rf_w_en_q   <= rf_w_en_d;
      rf_rd_q     <= rf_rd_d;
      rf_w_data_q <= rf_w_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_w_en   = rf_w_en_q;
  assign rf_rd     = rf_rd_q;
  assign rf_w_data = rf_w_data_q;
  assign busy_vec  = busy_q;
  assign rs1_busy  = (chk_rs1 != 5'd0) & busy_q[chk_rs1];
  assign rs2_busy  = (chk_rs2 != 5'd0) & busy_q[chk_rs2];

endmodule
